// File: rtl/exp_pkg.sv
// Shared types and helpers for the exponentiation feeder and its operand FIFO.
package exp_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_TAG_W = 2;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] base;
    logic [DEF_WIDTH-1:0] exp;
    logic [DEF_TAG_W-1:0] tag;
  } exp_req_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/exp_pair_fifo.sv
// Operand-pair FIFO; full/empty come from the occupancy count, pointers wrap naturally.
module exp_pair_fifo
  import exp_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type req_t = exp_req_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = level_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  req_t          push_data,
  input  logic          pop,
  output req_t          head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage is deliberately left unreset; only pointers and level matter.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/exp_feeder.sv
// Issue stage for the combinational exp core: operand FIFO in, tagged registered result out.
module exp_feeder
  import exp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_base,
  input  logic [WIDTH-1:0]          in_exp,
  output logic [WIDTH-1:0]          core_base,
  output logic [WIDTH-1:0]          core_exp,
  input  logic [WIDTH-1:0]          core_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_result,
  output logic [TAG_W-1:0]          out_tag,
  output logic [level_w(DEPTH)-1:0] level
);

  typedef struct packed {
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exp;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             push_data;
  req_t             head;
  logic             full;
  logic             empty;
  logic             push;
  logic             advance;
  logic [TAG_W-1:0] tag_cnt;

  // No bypass: a pop in the same cycle never reopens a full FIFO.
  assign in_ready  = !full;
  assign push      = in_valid && in_ready && !flush;
  assign advance   = !empty && (!out_valid || out_ready);
  assign push_data = '{base: in_base, exp: in_exp, tag: tag_cnt};
  assign core_base = empty ? '0 : head.base;
  assign core_exp  = empty ? '0 : head.exp;

  exp_pair_fifo #(
    .DEPTH (DEPTH),
    .req_t (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (advance),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Tag counter survives flush so downstream can spot the discarded gap.
  always_ff @(posedge clk) begin
    if (rst)       tag_cnt <= '0;
    else if (push) tag_cnt <= tag_cnt + TAG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (advance) begin
      out_valid  <= 1'b1;
      out_result <= core_result;
      out_tag    <= head.tag;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exp_feeder.sv
// Directed bench for exp_feeder with a behavioural exp core on the core_* port.
module tb_exp_feeder;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_base, in_exp, core_base, core_exp, core_result, out_result;
  logic [1:0] out_tag;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exp_feeder #(.WIDTH(8), .DEPTH(4), .TAG_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_base(in_base), .in_exp(in_exp),
    .core_base(core_base), .core_exp(core_exp), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .level(level)
  );

  function automatic logic [7:0] pow_mod(input logic [7:0] b, input logic [7:0] e);
    logic [7:0] r;
    r = 8'd1;
    for (int k = 0; k < int'(e); k++) r = r * b;
    return r;
  endfunction

  always_comb core_result = pow_mod(core_base, core_exp);

  typedef struct {
    logic       rst, flush, iv;
    logic [7:0] b, e;
    logic       ordy;
    logic       ov;
    logic [7:0] res;
    logic [1:0] tag;
    logic [2:0] lvl;
    logic       ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic f, logic iv, logic [7:0] b, logic [7:0] e, logic ordy,
                             logic ov, logic [7:0] res, logic [1:0] tag, logic [2:0] lvl, logic ir);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = iv; t.b = b; t.e = e; t.ordy = ordy;
    t.ov = ov; t.res = res; t.tag = tag; t.lvl = lvl; t.ir = ir;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %0d want %0d", name, idx, got, want);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [7:0] b,
                       input logic [7:0] e, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_base = b; in_exp = e; out_ready = ordy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_kill(input bit use_flush);
    logic [1:0] want_tag;
    bit         seen;
    drive(1, 0, 0, 0, 0, 1); cyc();
    drive(0, 0, 1, 1, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 1); cyc(); cyc();
    drive(0, 0, 1, 4, 1, 0); cyc();
    drive(0, 0, 1, 4, 2, 0); cyc();
    drive(0, 0, 1, 4, 3, 0); cyc();
    drive(0, 0, 1, 4, 0, 0); cyc();
    chk("pre_kill_level", 100, level, 3);
    chk("pre_kill_valid", 100, out_valid, 1);
    chk("pre_kill_core_base", 100, core_base, 4);
    chk("pre_kill_core_exp", 100, core_exp, 2);
    drive(!use_flush, use_flush, 1, 9, 9, 1); cyc();
    chk("kill_valid", 101, out_valid, 0);
    chk("kill_level", 101, level, 0);
    chk("kill_core_base", 101, core_base, 0);
    chk("kill_core_exp", 101, core_exp, 0);
    chk("kill_in_ready", 101, in_ready, 1);
    if (!use_flush) begin
      chk("kill_out_result", 101, out_result, 0);
      chk("kill_out_tag", 101, out_tag, 0);
    end
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("post_kill_no_valid", 102 + i, out_valid, 0);
    end
    // 5 requests were accepted before the kill, so tag_cnt sits at 1 unless reset.
    want_tag = use_flush ? 2'd1 : 2'd0;
    drive(0, 0, 1, 2, 3, 1); cyc();
    drive(0, 0, 0, 0, 0, 1);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      cyc();
      if (out_valid) begin
        seen = 1;
        chk("post_kill_result", 104, out_result, 8);
        chk("post_kill_tag", 104, out_tag, want_tag);
      end
    end
    chk("post_kill_seen", 105, seen, 1);
  endtask

  initial begin
    int n;
    drive(1, 0, 0, 0, 0, 1);
    // single op
    vecs.push_back(v(1,0,0, 0,0, 1, 0,  0,0, 0,1));
    vecs.push_back(v(0,0,1, 3,5, 1, 0,  0,0, 1,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 1,243,0, 0,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 0,  0,0, 0,1));
    // wrap and identity cases back-to-back
    vecs.push_back(v(1,0,0, 0,0, 1, 0,  0,0, 0,1));
    vecs.push_back(v(0,0,1, 2,8, 1, 0,  0,0, 1,1));
    vecs.push_back(v(0,0,1, 0,0, 1, 1,  0,0, 1,1));
    vecs.push_back(v(0,0,1, 1,255,1,1,  1,1, 1,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 1,  1,2, 0,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 0,  0,0, 0,1));
    // simultaneous push and pop at level 2
    vecs.push_back(v(1,0,0, 0,0, 1, 0,  0,0, 0,1));
    vecs.push_back(v(0,0,1, 2,1, 0, 0,  0,0, 1,1));
    vecs.push_back(v(0,0,1, 2,2, 0, 1,  2,0, 1,1));
    vecs.push_back(v(0,0,1, 2,3, 0, 1,  2,0, 2,1));
    vecs.push_back(v(0,0,1, 2,4, 1, 1,  4,1, 2,1));
    vecs.push_back(v(0,0,1, 2,5, 1, 1,  8,2, 2,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 1, 16,3, 1,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 1, 32,0, 0,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 0,  0,0, 0,1));
    // backpressure to full, then drain
    vecs.push_back(v(1,0,0, 0,0, 0, 0,  0,0, 0,1));
    vecs.push_back(v(0,0,1, 3,1, 0, 0,  0,0, 1,1));
    vecs.push_back(v(0,0,1, 3,2, 0, 1,  3,0, 1,1));
    vecs.push_back(v(0,0,1, 3,3, 0, 1,  3,0, 2,1));
    vecs.push_back(v(0,0,1, 3,4, 0, 1,  3,0, 3,1));
    vecs.push_back(v(0,0,1, 3,5, 0, 1,  3,0, 4,0));
    vecs.push_back(v(0,0,1, 9,9, 0, 1,  3,0, 4,0));
    vecs.push_back(v(0,0,1, 7,7, 1, 1,  9,1, 3,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 1, 27,2, 2,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 1, 81,3, 1,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 1,243,0, 0,1));
    vecs.push_back(v(0,0,0, 0,0, 1, 0,  0,0, 0,1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].b, vecs[i].e, vecs[i].ordy);
      cyc();
      chk("out_valid", i, out_valid, vecs[i].ov);
      chk("level", i, level, vecs[i].lvl);
      chk("in_ready", i, in_ready, vecs[i].ir);
      if (vecs[i].ov) begin
        chk("out_result", i, out_result, vecs[i].res);
        chk("out_tag", i, out_tag, vecs[i].tag);
      end
      if (vecs[i].rst) begin
        chk("rst_out_result", i, out_result, 0);
        chk("rst_out_tag", i, out_tag, 0);
        chk("rst_core_base", i, core_base, 0);
        chk("rst_core_exp", i, core_exp, 0);
      end
    end

    // tag wrap over 6 streamed requests at full throughput
    drive(1, 0, 0, 0, 0, 1); cyc();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 8'(i + 1), 2, 1); cyc();
      if (out_valid) begin
        chk("wrap_result", 200 + n, out_result, pow_mod(8'(n + 1), 2));
        chk("wrap_tag", 200 + n, out_tag, n % 4);
        n++;
      end
    end
    chk("wrap_throughput", 206, n, 5);
    drive(0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 10 && n < 6; j++) begin
      cyc();
      if (out_valid) begin
        chk("wrap_result", 200 + n, out_result, pow_mod(8'(n + 1), 2));
        chk("wrap_tag", 200 + n, out_tag, n % 4);
        n++;
      end
    end
    chk("wrap_count", 207, n, 6);

    run_kill(0);
    run_kill(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
